// File: rtl/key_scan_debounce.sv
// Front-panel key debouncer: one shared prescaler and one shared integrate/compare
// datapath, time-multiplexed across N_KEYS inputs by a small scan FSM.
module key_scan_debounce #(
  parameter int unsigned N_KEYS       = 4,
  parameter int unsigned TICK_DIV     = 65536,
  parameter int unsigned STABLE_TICKS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] in_i,
  output logic [N_KEYS-1:0] level_o,
  output logic [N_KEYS-1:0] press_o,
  output logic [N_KEYS-1:0] release_o,
  output logic              scan_busy_o
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned IW = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
  localparam int unsigned CW = $clog2(STABLE_TICKS + 1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  state_e                       state_q, state_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic [PW-1:0]                presc_q, presc_d;
  logic [N_KEYS-1:0]            sync1_q, sync2_q;
  logic [N_KEYS-1:0]            level_q, level_d;
  logic [N_KEYS-1:0]            press_q, press_d;
  logic [N_KEYS-1:0]            release_q, release_d;
  logic                         scan_busy_q, scan_busy_d;
  logic [N_KEYS-1:0][CW-1:0]    cnt_q, cnt_d;

  logic                         tick_c;
  logic                         samp_c;
  logic                         lvl_c;
  logic [CW-1:0]                cnt_inc_c;

  // Free-running sample prescaler; the terminal count is the scan tick.
  always_comb begin
    tick_c  = (presc_q == PW'(TICK_DIV - 1));
    presc_d = tick_c ? '0 : presc_q + PW'(1);
  end

  // Two-flop synchroniser for the raw asynchronous key pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in_i;
      sync2_q <= sync1_q;
    end
  end

  // Scan FSM next state plus the shared integrate/compare step for key idx_q.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    cnt_d     = cnt_q;
    samp_c    = sync2_q[idx_q];
    lvl_c     = level_q[idx_q];
    cnt_inc_c = cnt_q[idx_q] + CW'(1);

    case (state_q)
      IDLE: begin
        if (tick_c) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        // A tick landing here is ignored; the scan simply runs to completion.
        if (samp_c == lvl_c) begin
          cnt_d[idx_q] = '0;
        end else if (cnt_inc_c == CW'(STABLE_TICKS)) begin
          level_d[idx_q]   = ~lvl_c;
          cnt_d[idx_q]     = '0;
          press_d[idx_q]   = ~lvl_c;
          release_d[idx_q] = lvl_c;
        end else begin
          cnt_d[idx_q] = cnt_inc_c;
        end

        if (idx_q == IW'(N_KEYS - 1)) begin
          state_d = IDLE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    scan_busy_d = (state_d == SCAN);
  end

  // State, counters and registered outputs; reset abandons any scan in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      presc_q     <= '0;
      level_q     <= '0;
      press_q     <= '0;
      release_q   <= '0;
      scan_busy_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      presc_q     <= presc_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      scan_busy_q <= scan_busy_d;
      cnt_q       <= cnt_d;
    end
  end

  assign level_o     = level_q;
  assign press_o     = press_q;
  assign release_o   = release_q;
  assign scan_busy_o = scan_busy_q;

endmodule

// File: tb/tb_key_scan_debounce.sv
// Scoreboard bench for key_scan_debounce with N_KEYS=4, TICK_DIV=16, STABLE_TICKS=4.
// Cycle c counts rising edges since reset release; sample ticks fall on c%16==15.
module tb_key_scan_debounce;

  localparam int unsigned N_KEYS       = 4;
  localparam int unsigned TICK_DIV     = 16;
  localparam int unsigned STABLE_TICKS = 4;

  typedef struct {
    int cyc;
    int key;
    bit is_press;
  } ev_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [N_KEYS-1:0] in_r = '0;
  logic [N_KEYS-1:0] level_o;
  logic [N_KEYS-1:0] press_o;
  logic [N_KEYS-1:0] release_o;
  logic              scan_busy_o;

  int   cyc;
  int   n_checks = 0;
  int   n_errors = 0;
  ev_t  exp_q[$];

  key_scan_debounce #(
    .N_KEYS      (N_KEYS),
    .TICK_DIV    (TICK_DIV),
    .STABLE_TICKS(STABLE_TICKS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_i       (in_r),
    .level_o    (level_o),
    .press_o    (press_o),
    .release_o  (release_o),
    .scan_busy_o(scan_busy_o)
  );

  always #5 clk = ~clk;

  // Bench cycle reference, restarted by reset like the DUT prescaler.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic expect_ev(input int c, input int k, input bit p);
    ev_t e;
    e.cyc = c;
    e.key = k;
    e.is_press = p;
    exp_q.push_back(e);
  endtask

  // Advance one cycle and pop/compare every strobe the DUT shows.
  task automatic step();
    ev_t e;
    @(negedge clk);
    if (rst_n && ((press_o | release_o) != '0)) begin
      n_checks++;
      if (($countones(press_o | release_o) != 1) || ((press_o & release_o) != '0)) begin
        n_errors++;
        $display("FAIL strobe_shape cyc=%0d press=%b release=%b want one strobe", cyc, press_o, release_o);
      end
      for (int k = 0; k < N_KEYS; k++) begin
        if (press_o[k] || release_o[k]) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_strobe cyc=%0d key=%0d press=%0b want none", cyc, k, press_o[k]);
          end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.key != k || e.is_press != press_o[k]) begin
              n_errors++;
              $display("FAIL strobe cyc=%0d key=%0d press=%0b want cyc=%0d key=%0d press=%0b",
                       cyc, k, press_o[k], e.cyc, e.key, e.is_press);
            end
          end
        end
      end
    end
  endtask

  task automatic run_to(input int target);
    int guard;
    guard = 0;
    while (cyc < target && guard < 5000) begin
      step();
      guard++;
    end
    n_checks++;
    if (cyc != target) begin
      n_errors++;
      $display("FAIL run_to cyc=%0d want=%0d", cyc, target);
    end
  endtask

  task automatic test_reset();
    in_r = 4'hF;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (level_o !== 4'h0) begin n_errors++; $display("FAIL rst_level got=%h want=0", level_o); end
    n_checks++;
    if ((press_o | release_o) !== 4'h0) begin
      n_errors++; $display("FAIL rst_strobes got=%h/%h want=0", press_o, release_o);
    end
    n_checks++;
    if (scan_busy_o !== 1'b0) begin n_errors++; $display("FAIL rst_busy got=%b want=0", scan_busy_o); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < N_KEYS; k++) expect_ev(65 + k, k, 1'b1);
    run_to(63);
    n_checks++;
    if (scan_busy_o !== 1'b0) begin n_errors++; $display("FAIL busy_tick got=%b want=0", scan_busy_o); end
    run_to(64);
    n_checks++;
    if (level_o !== 4'h0) begin n_errors++; $display("FAIL level_3ticks got=%h want=0", level_o); end
    n_checks++;
    if (scan_busy_o !== 1'b1) begin n_errors++; $display("FAIL busy_scan got=%b want=1", scan_busy_o); end
    run_to(68);
    n_checks++;
    if (scan_busy_o !== 1'b0) begin n_errors++; $display("FAIL busy_end got=%b want=0", scan_busy_o); end
    run_to(69);
    n_checks++;
    if (level_o !== 4'hF) begin n_errors++; $display("FAIL level_4ticks got=%h want=f", level_o); end
    n_checks++;
    if (exp_q.size() != 0) begin n_errors++; $display("FAIL reset_pending got=%0d want=0", exp_q.size()); end
  endtask

  task automatic do_reset(input logic [N_KEYS-1:0] val);
    @(negedge clk);
    in_r  = val;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_press();
    do_reset(4'h0);
    run_to(4);
    in_r = 4'b0100;
    expect_ev(67, 2, 1'b1);
    run_to(66);
    n_checks++;
    if (level_o !== 4'b0000) begin n_errors++; $display("FAIL press_early got=%b want=0000", level_o); end
    run_to(67);
    n_checks++;
    if (level_o !== 4'b0100) begin n_errors++; $display("FAIL press_level got=%b want=0100", level_o); end
    n_checks++;
    if (press_o !== 4'b0100) begin n_errors++; $display("FAIL press_strobe got=%b want=0100", press_o); end
    run_to(68);
    n_checks++;
    if (press_o !== 4'b0000) begin n_errors++; $display("FAIL press_width got=%b want=0000", press_o); end
    run_to(70);
    n_checks++;
    if (exp_q.size() != 0) begin n_errors++; $display("FAIL press_pending got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_bounce();
    int b;
    run_to(84);
    for (int i = 0; i < 10; i++) begin
      b = 84 + 64 * i;
      run_to(b);
      in_r = 4'b0110;
      run_to(b + 48);
      in_r = 4'b0100;
      run_to(b + 64);
      n_checks++;
      if (level_o !== 4'b0100) begin
        n_errors++; $display("FAIL bounce_level round=%0d got=%b want=0100", i, level_o);
      end
    end
  endtask

  task automatic test_release();
    run_to(724);
    in_r = 4'b0000;
    expect_ev(787, 2, 1'b0);
    run_to(786);
    n_checks++;
    if (level_o !== 4'b0100) begin n_errors++; $display("FAIL rel_early got=%b want=0100", level_o); end
    run_to(787);
    n_checks++;
    if (level_o !== 4'b0000) begin n_errors++; $display("FAIL rel_level got=%b want=0000", level_o); end
    n_checks++;
    if (release_o !== 4'b0100 || press_o !== 4'b0000) begin
      n_errors++; $display("FAIL rel_strobe got=%b/%b want 0100/0000", release_o, press_o);
    end
    run_to(800);
    n_checks++;
    if (exp_q.size() != 0) begin n_errors++; $display("FAIL rel_pending got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int busy;
    int first;
    busy  = 0;
    first = -1;
    run_to(804);
    in_r = 4'hF;
    for (int k = 0; k < N_KEYS; k++) expect_ev(865 + k, k, 1'b1);
    run_to(855);
    for (int c = 856; c <= 879; c++) begin
      run_to(c);
      if (scan_busy_o) begin
        busy++;
        if (first < 0) first = c;
      end
    end
    n_checks++;
    if (busy != 4) begin n_errors++; $display("FAIL busy_count got=%0d want=4", busy); end
    n_checks++;
    if (first != 864) begin n_errors++; $display("FAIL busy_start got=%0d want=864", first); end
    n_checks++;
    if (level_o !== 4'hF) begin n_errors++; $display("FAIL all_level got=%h want=f", level_o); end
    n_checks++;
    if (exp_q.size() != 0) begin n_errors++; $display("FAIL all_pending got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_reset_midscan();
    run_to(884);
    in_r = 4'h0;
    expect_ev(945, 0, 1'b0);
    expect_ev(946, 1, 1'b0);
    run_to(946);
    n_checks++;
    if (level_o !== 4'b1100 || scan_busy_o !== 1'b1) begin
      n_errors++; $display("FAIL mid_pre got=%b busy=%b want=1100 busy=1", level_o, scan_busy_o);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (scan_busy_o !== 1'b0 || (press_o | release_o) !== 4'h0 || level_o !== 4'h0) begin
      n_errors++;
      $display("FAIL mid_async busy=%b press=%b release=%b level=%b want all 0",
               scan_busy_o, press_o, release_o, level_o);
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_errors++; $display("FAIL mid_pending got=%0d want=0", exp_q.size()); end
    in_r = 4'b1010;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expect_ev(66, 1, 1'b1);
    expect_ev(68, 3, 1'b1);
    run_to(64);
    n_checks++;
    if (level_o !== 4'b0000) begin n_errors++; $display("FAIL redeb_early got=%b want=0000", level_o); end
    run_to(69);
    n_checks++;
    if (level_o !== 4'b1010) begin n_errors++; $display("FAIL redeb_level got=%b want=1010", level_o); end
    n_checks++;
    if (exp_q.size() != 0) begin n_errors++; $display("FAIL redeb_pending got=%0d want=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_release();
    test_back_to_back();
    test_reset_midscan();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
